// File: rtl/mrsc_pkg.sv
// MRSC shared definitions: code layout, buffer states and the encode function.
// The decoder imports this same package so both sides use identical equations.
package mrsc_pkg;

    localparam int CODE_W = 32;
    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] mrsc_data_t;
    typedef logic [CODE_W-1:0] mrsc_code_t;

    localparam int DI1_POS  = 15;
    localparam int DI2_POS  = 14;
    localparam int DI3_POS  = 13;
    localparam int DI4_POS  = 12;
    localparam int P1_POS   = 11;
    localparam int P2_POS   = 10;
    localparam int P3_POS   = 9;
    localparam int P4_POS   = 8;
    localparam int XD17_POS = 7;
    localparam int XD18_POS = 6;
    localparam int XD19_POS = 5;
    localparam int XD20_POS = 4;
    localparam int XD21_POS = 3;
    localparam int XD22_POS = 2;
    localparam int XD23_POS = 1;
    localparam int XD24_POS = 0;

    typedef enum logic [1:0] {
        FIFO_EMPTY,
        FIFO_ONE,
        FIFO_FULL
    } fifo_state_e;

    function automatic int lane_idx_w(int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    function automatic mrsc_code_t mrsc_encode(mrsc_data_t d);
        mrsc_code_t c;
        c = '0;
        c[CODE_W-1:DATA_W] = d;
        c[DI1_POS]  = d[0] ^ d[5] ^ d[8] ^ d[13];
        c[DI2_POS]  = d[1] ^ d[4] ^ d[9] ^ d[12];
        c[DI3_POS]  = d[2] ^ d[7] ^ d[10] ^ d[15];
        c[DI4_POS]  = d[3] ^ d[6] ^ d[11] ^ d[14];
        c[P1_POS]   = d[0] ^ d[4] ^ d[8] ^ d[12];
        c[P2_POS]   = d[1] ^ d[5] ^ d[9] ^ d[13];
        c[P3_POS]   = d[2] ^ d[6] ^ d[10] ^ d[14];
        c[P4_POS]   = d[3] ^ d[7] ^ d[11] ^ d[15];
        c[XD17_POS] = d[0] ^ d[2];
        c[XD18_POS] = d[1] ^ d[3];
        c[XD19_POS] = d[4] ^ d[6];
        c[XD20_POS] = d[5] ^ d[7];
        c[XD21_POS] = d[8] ^ d[10];
        c[XD22_POS] = d[9] ^ d[11];
        c[XD23_POS] = d[12] ^ d[14];
        c[XD24_POS] = d[13] ^ d[15];
        return c;
    endfunction

endpackage

// File: rtl/mrsc_encoder_stream_if.sv
// Beat-level handshake bundle between data source, encoder and sink.
// slave is the encoder's view; master is the source/sink view.
interface mrsc_encoder_stream_if #(
    parameter int LANES = 4
);
    import mrsc_pkg::*;

    localparam int LW = lane_idx_w(LANES);

    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W*LANES-1:0]   in_data;
    logic                      inj_en;
    logic [LW-1:0]             inj_lane;
    logic [4:0]                inj_bit;
    logic                      out_valid;
    logic                      out_ready;
    logic [CODE_W*LANES-1:0]   out_code;
    logic                      out_injected;

    modport master (
        output in_valid, in_data, inj_en, inj_lane, inj_bit, out_ready,
        input  in_ready, out_valid, out_code, out_injected
    );

    modport slave (
        input  in_valid, in_data, inj_en, inj_lane, inj_bit, out_ready,
        output in_ready, out_valid, out_code, out_injected
    );

endinterface

// File: rtl/mrsc_skid_fifo.sv
// Two-entry valid/ready buffer; push_ready is a flop so there is no
// combinational path from pop_ready back to the producer.
module mrsc_skid_fifo
    import mrsc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data
);

    fifo_state_e  state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         ready_q, ready_d;
    logic         push, pop;

    assign push = push_valid && ready_q;
    assign pop  = pop_valid && pop_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FIFO_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            FIFO_EMPTY: begin
                if (push) begin
                    head_d  = push_data;
                    state_d = FIFO_ONE;
                end
            end
            FIFO_ONE: begin
                if (push && pop) begin
                    head_d = push_data;
                end else if (push) begin
                    tail_d  = push_data;
                    state_d = FIFO_FULL;
                end else if (pop) begin
                    state_d = FIFO_EMPTY;
                end
            end
            FIFO_FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    state_d = FIFO_ONE;
                end
            end
            default: state_d = FIFO_EMPTY;
        endcase
        ready_d = (state_d != FIFO_FULL);
    end

    always_comb begin
        pop_valid  = (state_q != FIFO_EMPTY);
        push_ready = ready_q;
        pop_data   = head_q;
    end

endmodule

// File: rtl/mrsc_encoder_stream.sv
// Multi-lane MRSC encoder with optional single-bit error injection,
// a two-entry skid buffer and a saturating output beat counter.
module mrsc_encoder_stream
    import mrsc_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    mrsc_encoder_stream_if.slave s,
    output logic [CNT_W-1:0]     beat_cnt
);

    localparam int PW = CODE_W*LANES + 1;

    logic [CODE_W*LANES-1:0] enc;
    logic                    inj_hit;
    logic [PW-1:0]           fifo_out;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    assign inj_hit = s.inj_en && (int'(s.inj_lane) < LANES);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mrsc_code_t code;
        always_comb begin
            code = mrsc_encode(s.in_data[DATA_W*i +: DATA_W]);
            if (inj_hit && int'(s.inj_lane) == i) begin
                code[s.inj_bit] = ~code[s.inj_bit];
            end
        end
        assign enc[CODE_W*i +: CODE_W] = code;
    end

    mrsc_skid_fifo #(
        .W(PW)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (s.in_valid),
        .push_ready (s.in_ready),
        .push_data  ({inj_hit, enc}),
        .pop_valid  (s.out_valid),
        .pop_ready  (s.out_ready),
        .pop_data   (fifo_out)
    );

    assign s.out_code     = fifo_out[CODE_W*LANES-1:0];
    assign s.out_injected = fifo_out[PW-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (s.out_valid && s.out_ready && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign beat_cnt = cnt_q;

endmodule

// File: tb/tb_mrsc_encoder_stream.sv
// Randomised scoreboard bench for mrsc_encoder_stream.
// A parity-mask reference model predicts each accepted beat.
module tb_mrsc_encoder_stream;
    import mrsc_pkg::*;

    localparam int LANES = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    // mask of data bits feeding code bit k (index = code bit)
    localparam logic [15:0] MASK [16] = '{
        16'hA000, 16'h5000, 16'h0A00, 16'h0500,
        16'h00A0, 16'h0050, 16'h000A, 16'h0005,
        16'h8888, 16'h4444, 16'h2222, 16'h1111,
        16'h4848, 16'h8484, 16'h1212, 16'h2121
    };

    typedef struct {
        logic [127:0] code;
        logic         inj;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mrsc_encoder_stream_if #(.LANES(LANES)) bus ();
    mrsc_encoder_stream_if #(.LANES(3))     bus3 ();
    logic [CNT_W-1:0] beat_cnt;
    logic [7:0]       beat_cnt3;

    mrsc_encoder_stream #(
        .LANES(LANES),
        .CNT_W(CNT_W)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .s        (bus),
        .beat_cnt (beat_cnt)
    );

    mrsc_encoder_stream #(
        .LANES(3),
        .CNT_W(8)
    ) u_dut3 (
        .clk      (clk),
        .rst      (rst),
        .s        (bus3),
        .beat_cnt (beat_cnt3)
    );

    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    int   exp_cnt = 0;
    int   rdy_mode = 0;

    logic [127:0] prev_code;
    logic         prev_inj;
    bit           prev_stall = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [63:0] d,
                                           input int nl, input logic en,
                                           input int ln, input int b);
        logic [127:0] r;
        logic [15:0]  w;
        r = '0;
        for (int l = 0; l < nl; l++) begin
            w = d[16*l +: 16];
            r[32*l+16 +: 16] = w;
            for (int k = 0; k < 16; k++) begin
                r[32*l+k] = ^(w & MASK[k]);
            end
        end
        if (en && ln < nl) begin
            r[32*ln+b] = ~r[32*ln+b];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
        endcase
    end

    // monitor: counter model, stall stability and in-order scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_stall = 0;
        end else begin
            chk("beat_cnt", 128'(beat_cnt), 128'(exp_cnt));
            if (prev_stall) begin
                chk("stall_hold", {bus.out_valid, bus.out_injected,
                                   bus.out_code},
                    {1'b1, prev_inj, prev_code});
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat code=%h", bus.out_code);
                end else begin
                    e = q.pop_front();
                    chk("out_code", bus.out_code, e.code);
                    chk("out_injected", 128'(bus.out_injected),
                        128'(e.inj));
                end
                exp_cnt = (exp_cnt == CMAX) ? CMAX : exp_cnt + 1;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_code  = bus.out_code;
            prev_inj   = bus.out_injected;
        end
    end

    task automatic send(input logic [63:0] d, input logic en,
                        input int ln, input int b,
                        input bit use_k, input logic [127:0] k);
        bit   acc;
        exp_t e;
        acc = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.inj_en   = en;
        bus.inj_lane = 2'(ln);
        bus.inj_bit  = 5'(b);
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout act=0 exp=1");
        end else begin
            e.code = use_k ? k : model(d, LANES, en, ln, b);
            e.inj  = en && (ln < LANES);
            q.push_back(e);
        end
    endtask

    task automatic send_rand();
        send({$urandom, $urandom}, 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(0, 31), 0, '0);
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && q.size() > 0; n++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_left", 128'(q.size()), 128'(0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        exp_cnt = 0;
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_in_ready", 128'(bus.in_ready), 128'(0));
        chk("rst_beat_cnt", 128'(beat_cnt), 128'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("post_rst_out_valid", 128'(bus.out_valid), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]  dc;
        logic [47:0]  d3;
        int           b3;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.inj_en    = 1'b0;
        bus.inj_lane  = '0;
        bus.inj_bit   = '0;
        bus3.in_valid = 1'b0;
        bus3.in_data  = '0;
        bus3.inj_en   = 1'b0;
        bus3.inj_lane = '0;
        bus3.inj_bit  = '0;
        bus3.out_ready = 1'b1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("in_ready_in_rst", 128'(bus.in_ready), 128'(0));
        chk("out_valid_in_rst", 128'(bus.out_valid), 128'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_in_ready", 128'(bus.in_ready), 128'(1));
        chk("reset_out_code", bus.out_code, 128'(0));
        chk("reset_out_inj", 128'(bus.out_injected), 128'(0));

        // known vectors
        send({16'hFFFF, 16'h8000, 16'h0001, 16'h0000}, 0, 0, 0, 1,
             {32'hFFFF0000, 32'h80002101, 32'h00018880, 32'h00000000});
        @(posedge clk);
        #1;
        chk("cnt_after_first", 128'(beat_cnt), 128'(1));
        send({16'h0000, 16'h0000, 16'h0001, 16'h0000}, 1, 1, 15, 1,
             {32'h0, 32'h0, 32'h00010880, 32'h0});
        drain();

        // backpressure: two accepted, third blocked until a pop
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send_rand();
        send_rand();
        dc = {$urandom, $urandom};
        bus.in_valid = 1'b1;
        bus.in_data  = dc;
        bus.inj_en   = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("full_in_ready", 128'(bus.in_ready), 128'(0));
        end
        @(posedge clk);
        #1;
        rdy_mode = 0;
        send(dc, 0, 0, 0, 0, '0);
        drain();

        // steady accept+pop in ONE state
        for (int i = 0; i < 100; i++) begin
            send_rand();
            chk("one_state", {126'd0, bus.out_valid, bus.in_ready},
                128'(3));
        end
        drain();

        // random backpressure and random gaps
        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            send_rand();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
        rdy_mode = 0;
        drain();

        // mid-stream reset with a full buffer
        rdy_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        send_rand();
        send_rand();
        chk("pre_rst_full", 128'(bus.in_ready), 128'(0));
        do_reset();
        rdy_mode = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("no_stale_beat", 128'(bus.out_valid), 128'(0));
        end

        // saturation of the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            send_rand();
        end
        drain();
        @(posedge clk);
        #1;
        chk("cnt_saturated", 128'(beat_cnt), 128'(CMAX));

        // 3-lane instance: out-of-range lane is ignored, in-range flips
        for (int t = 0; t < 2; t++) begin
            d3 = {$urandom, $urandom};
            b3 = $urandom_range(0, 31);
            bus3.in_valid = 1'b1;
            bus3.in_data  = d3;
            bus3.inj_en   = 1'b1;
            bus3.inj_lane = (t == 0) ? 2'd3 : 2'd2;
            bus3.inj_bit  = 5'(b3);
            @(posedge clk);
            #1;
            bus3.in_valid = 1'b0;
            chk("l3_valid", 128'(bus3.out_valid), 128'(1));
            chk("l3_code", 128'(bus3.out_code),
                model({16'h0, d3}, 3, 1'b1, (t == 0) ? 3 : 2, b3));
            chk("l3_inj", 128'(bus3.out_injected), 128'(t));
        end
        @(posedge clk);
        #1;
        chk("l3_cnt", 128'(beat_cnt3), 128'(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
